// File: rtl/mem_access_unit.sv
// Load/store unit between EX and data memory: width decode, byte lanes, two-beat split for unaligned accesses.
// Latency: 2 cycles single beat, 3 split, 1 on illegal Funct3; req_ready is high only while idle.
module mem_access_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  split_q;
    logic [DM_ADDRESS-1:0] addr1_q;
    logic [3:0]            be1_q;
    logic [31:0]           wd1_q;
    logic [31:0]           rd0_q;

    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [DM_ADDRESS-1:0] mem_addr_q;
    logic [3:0]            mem_be_q;
    logic [31:0]           mem_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;

    // Request-side decode, only consumed at the accept edge
    logic [1:0]            in_off;
    logic [7:0]            in_base;
    logic [7:0]            in_mask;
    logic [63:0]           in_sh;
    logic                  in_legal;
    logic [DM_ADDRESS-1:0] in_addr0;

    always_comb begin
        in_off = req_addr[1:0];
        case (req_funct3[1:0])
            2'b00:   in_base = 8'h01;
            2'b01:   in_base = 8'h03;
            default: in_base = 8'h0F;
        endcase
        in_mask  = in_base << in_off;
        in_sh    = {32'b0, req_wdata} << {in_off, 3'b000};
        in_addr0 = {req_addr[DM_ADDRESS-1:2], 2'b00};
        if (req_we) begin
            in_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            in_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b0;
            off_q       <= 2'b0;
            split_q     <= 1'b0;
            addr1_q     <= '0;
            be1_q       <= 4'b0;
            wd1_q       <= 32'b0;
            rd0_q       <= 32'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0;
            mem_wdata_q <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= in_off;
                        split_q <= |in_mask[7:4];
                        addr1_q <= in_addr0 + DM_ADDRESS'(4);
                        be1_q   <= in_mask[7:4];
                        wd1_q   <= in_sh[63:32];
                        if (!in_legal) begin
                            state_q     <= S_ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_ACC0;
                            mem_re_q    <= !req_we;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= in_addr0;
                            mem_be_q    <= in_mask[3:0];
                            mem_wdata_q <= in_sh[31:0];
                        end
                    end
                end
                S_ACC0: begin
                    if (split_q) begin
                        state_q     <= S_ACC1;
                        mem_addr_q  <= addr1_q;
                        mem_be_q    <= be1_q;
                        mem_wdata_q <= wd1_q;
                    end else begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= 4'b0;
                        mem_wdata_q <= 32'b0;
                    end
                end
                S_ACC1: begin
                    // Beat0 read data arrives now; beat1 data arrives during DONE
                    rd0_q       <= mem_rdata;
                    state_q     <= S_DONE;
                    rsp_valid_q <= 1'b1;
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_be_q    <= 4'b0;
                    mem_wdata_q <= 32'b0;
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
                S_ERR: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Merge: the final memory word is only present during DONE, so the
    // realignment runs in that cycle from the captured beat0 word.
    logic [31:0] lo_w;
    logic [31:0] hi_w;
    logic [31:0] shifted;
    logic [31:0] ext;

    always_comb begin
        lo_w    = split_q ? rd0_q : mem_rdata;
        hi_w    = split_q ? mem_rdata : 32'b0;
        shifted = 32'({hi_w, lo_w} >> {off_q, 3'b000});
        case (f3_q[1:0])
            2'b00:   ext = f3_q[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = f3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (state_q == S_DONE && !we_q) ? ext : 32'b0;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit between the EX stage and the data memory of the RV32I core. It accepts one load or store per handshake and decodes the RISC-V width from Funct3. It drives the word-aligned data memory with per-byte write enables and splits any access that crosses a word boundary into two sequential beats. Read bytes are merged, realigned and sign/zero-extended before returning to the pipeline. The pipeline stalls on `req_ready` low.

## Interface
- `DM_ADDRESS`, 9: byte-address width of the data memory.
- `DATA_W`, 32: data width; only 32 is supported.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: instruction bits 14:12.
- `req_addr` in DM_ADDRESS: byte address, the ALU result.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle pulse; the response is complete.
- `rsp_rdata` out 32: extended load result; 0 for stores and errors.
- `rsp_err` out 1: illegal Funct3; qualified by `rsp_valid`.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out DM_ADDRESS: word-aligned byte address; bits [1:0] are always 0.
- `mem_be` out 4: byte enables; bit i = byte lane i.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_rdata` in 32: read word, valid the cycle after `mem_re`.

## Operation
- **Width decode:**
  - Size n = 1 / 2 / 4 bytes for Funct3[1:0] = 00 / 01 / 10.
  - Funct3[2] = 1 selects zero-extension (LBU, LHU).
  - Legal loads: 000, 001, 010, 100, 101.
  - Legal stores: 000, 001, 010.
  - Any other code is illegal: no memory strobe, and the response has `rsp_err`=1.
- **Lane mapping:**
  - o = addr[1:0]; M = ((1<<n)-1) << o, an 8-bit mask.
  - Beat0: `mem_addr` = {addr[DM_ADDRESS-1:2],2'b00}, `mem_be` = M[3:0], `mem_wdata` = (wdata << 8o)[31:0].
  - Beat1 exists iff M[7:4] ≠ 0.
  - Beat1: `mem_addr` = beat0 address + 4, wrapping modulo 2^DM_ADDRESS; `mem_be` = M[7:4]; `mem_wdata` = wdata >> 8(4−o).
  - Loads drive `mem_be` the same way; the memory ignores it on reads.
- **Read merge:**
  - Form {beat1 word, beat0 word}, or {32'b0, beat0 word} if there is no beat1.
  - Shift right by 8o and keep the low n bytes.
  - Sign-extend from bit 8n−1 unless Funct3[2] = 1.
- **FSM:**
  - IDLE: `req_ready`=1. On `req_valid`, latch the request; go to ERR if Funct3 is illegal, otherwise ACC0.
  - ACC0: drive beat0 with `mem_re` or `mem_we` = 1. Go to ACC1 if a split is needed, otherwise DONE.
  - ACC1: drive beat1 and capture beat0 `mem_rdata` (loads). Go to DONE.
  - DONE: capture the last `mem_rdata`, merge, `rsp_valid`=1. Go to IDLE.
  - ERR: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0. Go to IDLE.
- Outside ACC0/ACC1: `mem_re`, `mem_we`, `mem_be`, `mem_wdata` and `mem_addr` are 0.
- `mem_re` and `mem_we` are never high together.
- Request inputs are sampled only at the accept edge. Changes afterwards have no effect.

## Timing
- **Reset values:**
  - State IDLE.
  - `req_ready`=1 (combinational from the state).
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_re`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- **Latency, counted from the accept edge (cycle 0):**
  - Single beat: access in cycle 1, `rsp_valid` in cycle 2.
  - Split: accesses in cycles 1 and 2, `rsp_valid` in cycle 3.
  - Error: `rsp_valid` in cycle 1.
- **Throughput:** the next accept is possible in the cycle after `rsp_valid`, since `req_ready` is low from ACC0 through DONE/ERR.
- Response outputs are registered. `rsp_rdata` and `rsp_err` are valid only while `rsp_valid`=1 and are 0 otherwise.
- **Reset mid-operation:** all outputs return to reset values immediately (asynchronously). The request is dropped with no response. A store beat already issued stays written; the remaining beat is not issued.

## Test plan
Memory is preloaded with word 0x010 = 0x88776655 and word 0x014 = 0x44332211.
- **LW at 0x010:**
  - Cycle 1: `mem_addr`=0x010, `mem_be`=1111, `mem_re`=1.
  - Cycle 2: `rsp_rdata`=0x88776655.
- **LB / LBU at 0x013:**
  - LB returns 0xFFFFFF88; LBU returns 0x00000088.
  - Both are single beats with `mem_be`=1000.
- **LH at 0x013 (split):**
  - Beats: 0x010/be 1000, then 0x014/be 0001.
  - Cycle 3: `rsp_rdata`=0x00001188.
  - LW at 0x012 returns 0x22118877.
- **SW 0xAABBCCDD at 0x01E:**
  - Beat0: 0x01C, be 1100, wdata 0xCCDD0000.
  - Beat1: 0x020, be 0011, wdata 0x0000AABB.
  - `rsp_valid` in cycle 3 with `rsp_rdata`=0.
- **Wrap:** LW at 0x1FE gives beat0 0x1FC/be 1100 and beat1 0x000/be 0011.
- **Error and reset:**
  - Load with Funct3=011, or store with Funct3=100: no `mem_re`/`mem_we`; cycle 1 has `rsp_valid`=1 and `rsp_err`=1.
  - Reset asserted during ACC1 of a split store: `mem_we` drops the same cycle, no `rsp_valid`, and `req_ready`=1 after release.
